// File: rtl/npc_wb_pkg.sv
// -----------------------------------------------------------------------------
// npc_wb_pkg
// Shared definitions for the NPC writeback stage and the load extender:
//   - XLEN            : architectural register width (RV64)
//   - wb_state_e      : writeback FSM states
//   - F3_*            : load funct3 width/sign codes
// -----------------------------------------------------------------------------
package npc_wb_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_ext.sv
// -----------------------------------------------------------------------------
// load_ext
// Purely combinational load data aligner/extender. Also intended for reuse by
// the LSU bypass path.
// Ports:
//   rdata   in  DW  raw 8-byte-aligned load data
//   addr_lo in  3   byte offset of the access within the 8-byte word
//   funct3  in  3   load width/sign code
//   result  out DW  aligned and extended load value
// The data is shifted right by addr_lo bytes with zero fill, so any bytes that
// would lie beyond the top of the word read as zero (misalignment unchecked).
// funct3 = 3'b111 is treated as a full-width load.
// -----------------------------------------------------------------------------
module load_ext
  import npc_wb_pkg::*;
#(
  parameter int DW = XLEN
) (
  input  logic [DW-1:0] rdata,
  input  logic [2:0]    addr_lo,
  input  logic [2:0]    funct3,
  output logic [DW-1:0] result
);

  logic [DW-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_LB:   result = {{(DW-8){shifted[7]}},   shifted[7:0]};
      F3_LH:   result = {{(DW-16){shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{(DW-32){shifted[31]}}, shifted[31:0]};
      F3_LBU:  result = {{(DW-8){1'b0}},  shifted[7:0]};
      F3_LHU:  result = {{(DW-16){1'b0}}, shifted[15:0]};
      F3_LWU:  result = {{(DW-32){1'b0}}, shifted[31:0]};
      default: result = shifted;  // LD and the reserved 3'b111 code
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage of the NPC core: accepts one retiring instruction per
// handshake, waits for load data when needed, aligns/extends it and drives the
// register file write port (sole writer of the register file).
// Optional feature macro: WB_COMMIT_TRACE_EN adds a commit trace
// (commit_valid/commit_pc) and the PC latch behind it.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           instruction handshake
//   in_rd, in_result, in_is_load  destination, ALU result, load flag
//   in_funct3, in_addr_lo         load width/sign code and byte offset
//   in_pc                         instruction PC (trace only)
//   mem_rvalid, mem_rdata         load data return (single-cycle pulse)
//   rf_wen, rf_waddr, rf_wdata    registered register file write port
//   commit_valid, commit_pc       registered commit trace (macro only)
// The registered rf_* outputs *are* the WRITE cycle: they are loaded on the
// edge that enters WRITE, so a same-cycle accept in WRITE only touches the
// instruction latches and never disturbs the write in flight.
// -----------------------------------------------------------------------------
module wb_stage
  import npc_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_lo,
  input  logic [63:0]           in_pc,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic                  commit_valid,
  output logic [63:0]           commit_pc
`endif
);

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [2:0]            addr_lo_q, addr_lo_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  accept;

`ifdef WB_COMMIT_TRACE_EN
  logic [63:0] pc_q, pc_d;
  logic        commit_valid_q, commit_valid_d;
  logic [63:0] commit_pc_q, commit_pc_d;
`else
  logic unused_pc;
  assign unused_pc = ^in_pc;
`endif

  assign in_ready = !rst && (state_q != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  load_ext #(
    .DW(DATA_WIDTH)
  ) u_load_ext (
    .rdata  (mem_rdata),
    .addr_lo(addr_lo_q),
    .funct3 (funct3_q),
    .result (load_data)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
`ifdef WB_COMMIT_TRACE_EN
    pc_d           = pc_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
`endif

    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept) begin
          rd_d      = in_rd;
          funct3_d  = in_funct3;
          addr_lo_d = in_addr_lo;
`ifdef WB_COMMIT_TRACE_EN
          pc_d      = in_pc;
`endif
          if (in_is_load) begin
            state_d = WAIT_MEM;
          end else begin
            state_d = WRITE;
            // x0 retires without a write; the port keeps its last values.
            if (in_rd != '0) begin
              rf_wen_d   = 1'b1;
              rf_waddr_d = in_rd;
              rf_wdata_d = in_result;
            end
`ifdef WB_COMMIT_TRACE_EN
            commit_valid_d = 1'b1;
            commit_pc_d    = in_pc;
`endif
          end
        end
      end

      WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = WRITE;
          if (rd_q != '0) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = rd_q;
            rf_wdata_d = load_data;
          end
`ifdef WB_COMMIT_TRACE_EN
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef WB_COMMIT_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= '0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
    end else begin
      pc_q           <= pc_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
`endif

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage. A transaction-level reference model tracks
// which instruction is waiting for memory and which retirement is due on the
// next cycle; the DUT outputs are compared against it every cycle, and a set of
// directed scenarios adds literal expectations. Build with WB_COMMIT_TRACE_EN
// defined to also exercise the commit trace.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_result = '0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [2:0]  in_addr_lo = '0;
  logic [63:0] in_pc = '0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
`ifdef WB_COMMIT_TRACE_EN
  logic        commit_valid;
  logic [63:0] commit_pc;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rd       (in_rd),
    .in_result   (in_result),
    .in_is_load  (in_is_load),
    .in_funct3   (in_funct3),
    .in_addr_lo  (in_addr_lo),
    .in_pc       (in_pc),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
`ifdef WB_COMMIT_TRACE_EN
    ,
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc)
`endif
  );

  // Reference load extraction: gather the accessed bytes starting at the
  // offset (bytes past the word read as zero), then extend from the width.
  function automatic logic [63:0] ref_ext(logic [63:0] d, int lo, int f3);
    int nbytes;
    logic [63:0] r;
    r = '0;
    case (f3)
      0, 4:    nbytes = 1;
      1, 5:    nbytes = 2;
      2, 6:    nbytes = 4;
      default: nbytes = 8;
    endcase
    for (int i = 0; i < nbytes; i++)
      if (lo + i < 8) r[8*i +: 8] = d[8*(lo+i) +: 8];
    if (f3 < 3 && r[8*nbytes-1])
      for (int b = 8*nbytes; b < 64; b++) r[b] = 1'b1;
    return r;
  endfunction

  // ---------------- reference model ----------------
  logic        m_pending = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [2:0]  m_f3 = '0;
  logic [2:0]  m_lo = '0;
  logic [63:0] m_pc = '0;
  logic        exp_wen = 1'b0;
  logic [4:0]  exp_waddr = '0;
  logic [63:0] exp_wdata = '0;
  logic        exp_cv = 1'b0;
  logic [63:0] exp_cpc = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_rd      <= '0;
      m_f3      <= '0;
      m_lo      <= '0;
      m_pc      <= '0;
      exp_wen   <= 1'b0;
      exp_waddr <= '0;
      exp_wdata <= '0;
      exp_cv    <= 1'b0;
      exp_cpc   <= '0;
    end else begin
      exp_wen <= 1'b0;
      exp_cv  <= 1'b0;
      if (m_pending) begin
        if (mem_rvalid) begin
          m_pending <= 1'b0;
          exp_cv    <= 1'b1;
          exp_cpc   <= m_pc;
          if (m_rd != 0) begin
            exp_wen   <= 1'b1;
            exp_waddr <= m_rd;
            exp_wdata <= ref_ext(mem_rdata, int'(m_lo), int'(m_f3));
          end
        end
      end else if (in_valid) begin
        m_rd <= in_rd;
        m_f3 <= in_funct3;
        m_lo <= in_addr_lo;
        m_pc <= in_pc;
        if (in_is_load) begin
          m_pending <= 1'b1;
        end else begin
          exp_cv  <= 1'b1;
          exp_cpc <= in_pc;
          if (in_rd != 0) begin
            exp_wen   <= 1'b1;
            exp_waddr <= in_rd;
            exp_wdata <= in_result;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(in_ready), 64'(!rst && !m_pending));
    chk("rf_wen",   64'(rf_wen),   64'(exp_wen));
    chk("rf_waddr", 64'(rf_waddr), 64'(exp_waddr));
    chk("rf_wdata", rf_wdata,      exp_wdata);
`ifdef WB_COMMIT_TRACE_EN
    chk("commit_valid", 64'(commit_valid), 64'(exp_cv));
    chk("commit_pc",    commit_pc,         exp_cpc);
`endif
  endtask

  // Inputs change 2ns after the rising edge; outputs are checked on the
  // falling edge, well away from both.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic offer_alu(input logic [4:0] rd, input logic [63:0] res, input logic [63:0] pc);
    in_valid   = 1'b1;
    in_is_load = 1'b0;
    in_rd      = rd;
    in_result  = res;
    in_funct3  = 3'b000;
    in_addr_lo = 3'b000;
    in_pc      = pc;
  endtask

  task automatic offer_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lo,
                            input logic [63:0] pc);
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd      = rd;
    in_result  = 64'hDEAD_DEAD_DEAD_DEAD;
    in_funct3  = f3;
    in_addr_lo = lo;
    in_pc      = pc;
  endtask

  // Load with rvalid one cycle after accept; leaves the bench in the write cycle.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] lo,
                         input logic [63:0] data);
    offer_load(rd, f3, lo, 64'h1000);
    tick();
    set_idle();
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [63:0] res;

    // Pin the reference extraction itself.
    chk("model_lb",  ref_ext(64'h0000_0000_0080_0000, 2, 0), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model_lbu", ref_ext(64'h0000_0000_0080_0000, 2, 4), 64'h0000_0000_0000_0080);
    chk("model_lw",  ref_ext(64'h8765_4321_0BAD_F00D, 4, 2), 64'hFFFF_FFFF_8765_4321);
    chk("model_ld6", ref_ext(64'h8877_6655_4433_2211, 6, 3), 64'h0000_0000_0000_8877);

    // Reset
    rst = 1'b1;
    set_idle();
    tick(); tick(); tick();
    chk("reset_wen",   64'(rf_wen),   64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", rf_wdata,      64'd0);
    chk("reset_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    // ALU op rd=5, result 0x1234
    offer_alu(5'd5, 64'h1234, 64'h8000_0000);
    tick();
    set_idle();
    $display("txn: ALU rd=5 -> wen=%0d waddr=%0d wdata=0x%0h", rf_wen, rf_waddr, rf_wdata);
    chk("alu_wen",   64'(rf_wen),   64'd1);
    chk("alu_waddr", 64'(rf_waddr), 64'd5);
    chk("alu_wdata", rf_wdata,      64'h1234);
    tick();

    // LB / LBU, offset 2
    do_load(5'd7, 3'b000, 3'd2, 64'h0000_0000_0080_0000);
    $display("txn: LB rd=7 -> wdata=0x%0h", rf_wdata);
    chk("lb_wen",   64'(rf_wen), 64'd1);
    chk("lb_wdata", rf_wdata,    64'hFFFF_FFFF_FFFF_FF80);
    do_load(5'd8, 3'b100, 3'd2, 64'h0000_0000_0080_0000);
    $display("txn: LBU rd=8 -> wdata=0x%0h", rf_wdata);
    chk("lbu_wen",   64'(rf_wen),   64'd1);
    chk("lbu_waddr", 64'(rf_waddr), 64'd8);
    chk("lbu_wdata", rf_wdata,      64'h80);
    tick();

    // LW offset 4, data returned 5 cycles after accept
    offer_load(5'd9, 3'b010, 3'd4, 64'h2000);
    tick();
    set_idle();
    for (int k = 0; k < 4; k++) begin
      chk("lw_wait_ready", 64'(in_ready), 64'd0);
      chk("lw_wait_wen",   64'(rf_wen),   64'd0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h8765_4321_0BAD_F00D;
    chk("lw_rvalid_ready", 64'(in_ready), 64'd0);
    tick();
    mem_rvalid = 1'b0;
    $display("txn: LW rd=9 -> wdata=0x%0h", rf_wdata);
    chk("lw_wen",   64'(rf_wen), 64'd1);
    chk("lw_wdata", rf_wdata,    64'hFFFF_FFFF_8765_4321);
    tick();

    // ALU op to x0: retires without a write
    offer_alu(5'd0, 64'h5555, 64'h8000_0040);
    tick();
    set_idle();
    $display("txn: ALU rd=0 -> wen=%0d", rf_wen);
    chk("x0_wen",   64'(rf_wen),   64'd0);
    chk("x0_waddr", 64'(rf_waddr), 64'd9);
`ifdef WB_COMMIT_TRACE_EN
    chk("x0_commit_valid", 64'(commit_valid), 64'd1);
    chk("x0_commit_pc",    commit_pc,         64'h8000_0040);
`endif
    tick();

    // Four back-to-back ALU ops
    for (int k = 1; k <= 4; k++) begin
      res = 64'h1111 * 64'(k);
      offer_alu(5'(k + 16), res, 64'h3000 + 64'(4 * k));
      chk("b2b_ready", 64'(in_ready), 64'd1);
      tick();
      $display("txn: b2b ALU #%0d -> wen=%0d waddr=%0d wdata=0x%0h", k, rf_wen, rf_waddr, rf_wdata);
      chk("b2b_wen",   64'(rf_wen),   64'd1);
      chk("b2b_waddr", 64'(rf_waddr), 64'(k + 16));
      chk("b2b_wdata", rf_wdata,      res);
    end
    set_idle();
    tick();

    // Reset while waiting for memory, then a stray rvalid
    offer_load(5'd3, 3'b011, 3'd0, 64'h4000);
    tick();
    set_idle();
    tick();
    chk("rstwait_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hCAFE_F00D_1234_5678;
    tick();
    mem_rvalid = 1'b0;
    $display("txn: reset in WAIT_MEM + stray rvalid -> wen=%0d", rf_wen);
    chk("rstwait_wen",   64'(rf_wen),   64'd0);
    chk("rstwait_waddr", 64'(rf_waddr), 64'd0);
    chk("rstwait_wdata", rf_wdata,      64'd0);
    chk("rstwait_ready2", 64'(in_ready), 64'd1);
    offer_alu(5'd12, 64'hABCD, 64'h5000);
    tick();
    set_idle();
    chk("post_rst_wen",   64'(rf_wen),   64'd1);
    chk("post_rst_waddr", 64'(rf_waddr), 64'd12);
    chk("post_rst_wdata", rf_wdata,      64'hABCD);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      in_valid   = ($urandom_range(0, 9) < 6);
      in_is_load = ($urandom_range(0, 9) < 4);
      in_rd      = 5'($urandom);
      in_result  = {$urandom, $urandom};
      in_funct3  = 3'($urandom);
      in_addr_lo = 3'($urandom);
      in_pc      = {$urandom, $urandom};
      mem_rvalid = ($urandom_range(0, 9) < 3);
      mem_rdata  = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the NPC core. Accepts one retiring instruction per handshake from the execute/memory path, waits for load data when the instruction is a load, aligns and extends that data, and drives the register file write port (`rf_wen`/`rf_waddr`/`rf_wdata`). It sits directly upstream of the register file and is its only writer.

## Interface

Reset is synchronous and active-high; one clock `clk`, reset `rst`.

Parameters:
- `ADDR_WIDTH`, default 5: register index width.
- `DATA_WIDTH`, default 64: register/data width (RV64).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  retiring instruction offered.
- `in_ready`  out  1  stage can accept this cycle.
- `in_rd`  in  ADDR_WIDTH  destination register.
- `in_result`  in  DATA_WIDTH  ALU result, ignored for loads.
- `in_is_load`  in  1  instruction is a load.
- `in_funct3`  in  3  load width/sign code.
- `in_addr_lo`  in  3  load byte offset within the 8-byte word.
- `in_pc`  in  64  instruction PC, used only with `WB_COMMIT_TRACE_EN`.
- `mem_rvalid`  in  1  load data valid, single-cycle pulse.
- `mem_rdata`  in  DATA_WIDTH  raw 8-byte-aligned load data.
- `rf_wen`  out  1  register file write enable.
- `rf_waddr`  out  ADDR_WIDTH  register file write index.
- `rf_wdata`  out  DATA_WIDTH  register file write data.
- `commit_valid`  out  1  retirement pulse; present only with the macro.
- `commit_pc`  out  64  PC of the retiring instruction; present only with the macro.

## Operation

- FSM states: IDLE, WAIT_MEM, WRITE.
- `in_ready` is 1 in IDLE and in WRITE, 0 in WAIT_MEM, and 0 while `rst` is high.
- Accept occurs when `in_valid & in_ready`. On accept, latch `rd`, `funct3`, `addr_lo` and `pc`.
  - Non-load: latch `in_result` as the write data, then go to WRITE.
  - Load: go to WAIT_MEM.
- WAIT_MEM: hold until `mem_rvalid`. Then:
  - Shift `mem_rdata` right by `addr_lo*8`, zero-filling the top.
  - Extend by `funct3`: 000 LB sign-8, 001 LH sign-16, 010 LW sign-32, 011 LD, 100 LBU, 101 LHU, 110 LWU zero-extend.
  - 111 behaves as LD.
  - Latch the result and go to WRITE.
- WRITE lasts one cycle.
  - `rf_wen` = 1 unless the latched `rd` == 0. For `rd` == 0, `rf_wen` stays 0 but the instruction still retires.
  - If an accept happens in the same cycle, the next state follows the accept rule above; otherwise go to IDLE.
- `mem_rvalid` outside WAIT_MEM is ignored.
- Misalignment is not checked. Bytes shifted past bit 63 are simply lost.
- `rf_waddr` and `rf_wdata` hold their last values when `rf_wen` = 0.

## Timing

- All `rf_*` and `commit_*` outputs are registered.
- Reset values: `rf_wen` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `commit_valid` = 0, `commit_pc` = 0. State = IDLE.
- ALU op accepted in cycle N: `rf_wen` is high in cycle N+1.
- Back-to-back ALU ops sustain one write per cycle.
- Load accepted in cycle N, `mem_rvalid` in cycle M (M ≥ N+1): `rf_wen` is high in cycle M+1.
- Minimum load-to-write latency is 2 cycles.
- Reset mid-operation (WAIT_MEM or WRITE): the pending instruction is dropped, no write occurs, and the next cycle is IDLE.
- An accept and a WRITE-state write in the same cycle are legal. The write uses the old latched data; the new instruction overwrites the latches at the clock edge.

## Configuration

- `WB_COMMIT_TRACE_EN` defined:
  - The `commit_valid`/`commit_pc` ports and the PC latch exist.
  - `commit_valid` pulses in every WRITE cycle, including `rd` == 0, with `commit_pc` = the latched PC.
- Not defined:
  - The ports and the PC latch are absent.
  - `in_pc` is unused (lint waiver only).
  - All other behaviour is identical.

## Structure

- Package `npc_wb_pkg` holds:
  - the state enum (IDLE/WAIT_MEM/WRITE);
  - load `funct3` constants (LB, LH, LW, LD, LBU, LHU, LWU);
  - `XLEN` = 64.
- One combinational sub-module, `load_ext`, takes (`rdata`, `addr_lo`, `funct3`) and returns the extended value. It is shared later by the LSU bypass.

## Test plan

- ALU op `rd`=5, result 0x1234 accepted cycle 3 → `rf_wen`=1, `waddr`=5, `wdata`=0x1234 in cycle 4.
- LB `addr_lo`=2, `mem_rdata`=0x0000_0000_0080_0000 → `wdata`=0xFFFF_FFFF_FFFF_FF80. The same data with LBU → 0x80.
- LW `addr_lo`=4, `mem_rvalid` 5 cycles after accept → `in_ready`=0 throughout the wait, then `rf_wen` one cycle after `mem_rvalid` with the upper word sign-extended.
- ALU op `rd`=0 with the macro defined → `rf_wen` stays 0, `commit_valid`=1 with the correct `commit_pc`.
- Four back-to-back ALU ops → four consecutive `rf_wen` cycles, in order, with `in_ready` held at 1.
- `rst` pulsed while in WAIT_MEM, then a stray `mem_rvalid` → no `rf_wen`, all outputs 0, and the next accept works normally.
